regfile_mp: RTL

Parametrised multi-port integer register file with write-to-read bypass and a per-register pending scoreboard, for the pipelined RISC-V core. It replaces the single-write, dual-read register file in the decode/writeback path. It adds configurable read and write port counts and same-cycle forwarding of writeback data. It also tracks in-flight destination registers so decode can stall on RAW hazards without a separate hazard table.

---
 rtl/regfile_mp_if.sv | 41 ++++
 rtl/regfile_mp.sv | 103 ++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - port bundle for the multi-port register file
//
// Purpose: groups the read, write, issue and scoreboard signals of regfile_mp.
// Ports (seen from the register file, modport slave):
//   raddr_i   NUM_RD*REGW  read addresses, port k at [k*REGW +: REGW]
//   rdata_o   NUM_RD*XLEN  combinational read data
//   busy_o    NUM_RD       addressed register has an outstanding producer
//   we_i      NUM_WR       per-port write enable
//   waddr_i   NUM_WR*REGW  write addresses
//   wdata_i   NUM_WR*XLEN  write data
//   iss_valid_i / iss_rd_i issuing instruction and its destination register
//   flush_i                clears every pending bit
//   pend_o    NO_OF_REGS   registered pending vector
interface regfile_mp_if #(
  parameter int XLEN       = 32,
  parameter int NO_OF_REGS = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int REGW       = $clog2(NO_OF_REGS)
);
  logic [NUM_RD*REGW-1:0] raddr_i;
  logic [NUM_RD*XLEN-1:0] rdata_o;
  logic [NUM_RD-1:0]      busy_o;
  logic [NUM_WR-1:0]      we_i;
  logic [NUM_WR*REGW-1:0] waddr_i;
  logic [NUM_WR*XLEN-1:0] wdata_i;
  logic                   iss_valid_i;
  logic [REGW-1:0]        iss_rd_i;
  logic                   flush_i;
  logic [NO_OF_REGS-1:0]  pend_o;

  modport slave (
    input  raddr_i, we_i, waddr_i, wdata_i, iss_valid_i, iss_rd_i, flush_i,
    output rdata_o, busy_o, pend_o
  );

  modport master (
    output raddr_i, we_i, waddr_i, wdata_i, iss_valid_i, iss_rd_i, flush_i,
    input  rdata_o, busy_o, pend_o
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass and pending scoreboard
//
// Purpose: NO_OF_REGS x XLEN register file (x0 hardwired to zero) with NUM_RD
// combinational read ports, NUM_WR write ports (highest index wins on a
// collision), optional same-cycle write-to-read forwarding, and a per-register
// pending bit set on issue and cleared on writeback.
// Ports:
//   clk_i   clock, all state updates on the rising edge
//   rst_ni  synchronous active-low reset
//   rf      regfile_mp_if.slave bundle (reads, writes, issue, flush, pend_o)
module regfile_mp #(
  parameter int XLEN       = 32,
  parameter int NO_OF_REGS = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int BYPASS     = 1,
  parameter int REGW       = $clog2(NO_OF_REGS)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  regfile_mp_if.slave  rf
);

  // One extra bit so NO_OF_REGS itself is representable for the range check.
  localparam logic [REGW:0] NREGS = (REGW+1)'(NO_OF_REGS);

  function automatic logic valid_addr(input logic [REGW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS);
  endfunction

  logic [XLEN-1:0]       regs_q [NO_OF_REGS];
  logic [XLEN-1:0]       regs_d [NO_OF_REGS];
  logic [NO_OF_REGS-1:0] pend_q;
  logic [NO_OF_REGS-1:0] pend_d;

  logic [REGW-1:0] wa [NUM_WR];
  logic [XLEN-1:0] wd [NUM_WR];
  logic [REGW-1:0] ra [NUM_RD];

  for (genvar p = 0; p < NUM_WR; p++) begin : g_wunpack
    assign wa[p] = rf.waddr_i[p*REGW +: REGW];
    assign wd[p] = rf.wdata_i[p*XLEN +: XLEN];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_runpack
    assign ra[k] = rf.raddr_i[k*REGW +: REGW];
  end

  // Ports are applied in ascending order so the highest index lands last.
  // The issue set is applied after clears and flush: the newer producer wins.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (rf.we_i[p] && valid_addr(wa[p])) begin
        regs_d[wa[p]] = wd[p];
        pend_d[wa[p]] = 1'b0;
      end
    end
    if (rf.flush_i) begin
      pend_d = '0;
    end
    if (rf.iss_valid_i && valid_addr(rf.iss_rd_i)) begin
      pend_d[rf.iss_rd_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic            hit;
    logic [XLEN-1:0] val;
    logic            ok;

    // Forward from the highest matching enabled write port when bypassing.
    always_comb begin
      hit = 1'b0;
      val = regs_q[ra[k]];
      for (int p = 0; p < NUM_WR; p++) begin
        if ((BYPASS != 0) && rf.we_i[p] && (wa[p] == ra[k])) begin
          hit = 1'b1;
          val = wd[p];
        end
      end
    end

    assign ok                          = valid_addr(ra[k]);
    assign rf.rdata_o[k*XLEN +: XLEN]  = ok ? val : '0;
    assign rf.busy_o[k]                = ok & pend_q[ra[k]] & ~hit;
  end

  assign rf.pend_o = pend_q;

endmodule
